// File: rtl/xgmii_rx_monitor_if.sv
// XGMII receive bus: 64-bit data plus one control bit per byte lane.
// The PHY side drives it through the master modport, the monitor listens on slave.
interface xgmii_rx_monitor_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;

    modport master (output xgmii_rxd, output xgmii_rxc);
    modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/xgmii_rx_monitor.sv
// XGMII RX frame monitor: tracks start/terminate framing, classifies frame length, counts good/bad frames.
// Define XGMII_RX_MONITOR_STATS_EN to build the byte_cnt / last_len statistics logic.
module xgmii_rx_monitor #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                  clk156,
    input  logic                  sys_rst,
    xgmii_rx_monitor_if.slave     xgmii,
    input  logic                  clr,
    output logic                  in_frame,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [31:0]           good_cnt,
    output logic [31:0]           bad_cnt,
    output logic [47:0]           byte_cnt,
    output logic [15:0]           last_len
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    logic [63:0] rxd_q;
    logic [7:0]  rxc_q;
    logic [0:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] bad_cnt_q, bad_cnt_d;

    logic        is_start;
    logic [2:0]  lane_idx;
    logic [7:0]  lane_byte;
    logic [16:0] sum_data, sum_term;
    logic [15:0] len_plus8, len_term;
    logic        end_evt;
    logic        end_fd;
    logic        end_good;
    logic [15:0] end_len;

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_q <= 64'h0707070707070707;
            rxc_q <= 8'hFF;
        end else begin
            rxd_q <= xgmii.xgmii_rxd;
            rxc_q <= xgmii.xgmii_rxc;
        end
    end

    assign is_start = (rxc_q == 8'h01) && (rxd_q[7:0] == 8'hFB);

    // The lowest flagged lane decides how the frame ends.
    always_comb begin
        lane_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rxc_q[i]) lane_idx = 3'(i);
        end
    end

    assign lane_byte = rxd_q[{lane_idx, 3'b000} +: 8];

    assign sum_data  = {1'b0, len_q} + 17'd8;
    assign sum_term  = {1'b0, len_q} + {14'd0, lane_idx};
    assign len_plus8 = sum_data[16] ? 16'hFFFF : sum_data[15:0];
    assign len_term  = sum_term[16] ? 16'hFFFF : sum_term[15:0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        end_evt = 1'b0;
        end_fd  = 1'b0;
        end_len = len_q;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d = ST_FRAME;
                    len_d   = 16'd0;
                end
            end
            default: begin
                if (is_start) begin
                    // A new start aborts the current frame and opens the next one.
                    end_evt = 1'b1;
                    len_d   = 16'd0;
                end else if (rxc_q == 8'h00) begin
                    len_d = len_plus8;
                end else begin
                    end_evt = 1'b1;
                    state_d = ST_IDLE;
                    len_d   = 16'd0;
                    if (lane_byte == 8'hFD) begin
                        end_fd  = 1'b1;
                        end_len = len_term;
                    end
                end
            end
        endcase
    end

    assign end_good = end_fd && (end_len >= MIN_L) && (end_len <= MAX_L);

    always_comb begin
        frame_done_d = end_evt;
        frame_ok_d   = end_evt ? end_good : frame_ok_q;
        good_cnt_d   = good_cnt_q + 32'(end_evt && end_good);
        bad_cnt_d    = bad_cnt_q + 32'(end_evt && !end_good);
        if (clr) begin
            good_cnt_d = 32'd0;
            bad_cnt_d  = 32'd0;
        end
    end

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'd0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            good_cnt_q   <= 32'd0;
            bad_cnt_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

`ifdef XGMII_RX_MONITOR_STATS_EN
    logic [47:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] last_len_q, last_len_d;

    always_comb begin
        last_len_d = end_evt ? end_len : last_len_q;
        byte_cnt_d = byte_cnt_q + ((end_evt && end_good) ? {32'd0, end_len} : 48'd0);
        if (clr) byte_cnt_d = 48'd0;
    end

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            byte_cnt_q <= 48'd0;
            last_len_q <= 16'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            last_len_q <= last_len_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
    assign last_len = last_len_q;
`else
    assign byte_cnt = 48'd0;
    assign last_len = 16'd0;
`endif

    assign in_frame   = (state_q == ST_FRAME);
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;

endmodule

// File: doc/xgmii_rx_monitor.md
XGMII_RX_MONITOR -- requirements
Module: xgmii_rx_monitor

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum good frame length in bytes (DA through FCS).
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum good frame length in bytes.
REQ-003 SHALL have port clk156  input  1  sole clock, 156.25 MHz XGMII RX domain.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port xgmii_rxd  input  64  XGMII RX data, lane 0 = bits [7:0].
REQ-006 SHALL have port xgmii_rxc  input  8  XGMII RX control, bit i qualifies lane i.
REQ-007 SHALL have port clr  input  1  synchronous clear of all counters.
REQ-008 SHALL have port in_frame  output  1  high while a frame is being received.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse per frame end.
REQ-010 SHALL have port frame_ok  output  1  result of the frame flagged by frame_done, held until next frame_done.
REQ-011 SHALL have port good_cnt  output  32  count of good frames.
REQ-012 SHALL have port bad_cnt  output  32  count of bad frames.
REQ-013 SHALL have port byte_cnt  output  48  sum of good-frame lengths (stats option).
REQ-014 SHALL have port last_len  output  16  length of most recent ended frame (stats option).

Function
REQ-015 SHALL register xgmii_rxd/xgmii_rxc once before decoding; all decode acts on registered word.
REQ-016 SHALL implement states IDLE and FRAME; reset state IDLE.
REQ-017 SHALL detect start: rxc==8'h01 and lane 0 == 8'hFB; IDLE->FRAME, length cleared to 0; start word adds 0 bytes.
REQ-018 SHALL, in IDLE, ignore every non-start word (idles, errors, stray terminates); no counter changes.
REQ-019 SHALL, in FRAME, add 8 to length for each word with rxc==0.
REQ-020 SHALL, in FRAME, for word with rxc!=0, let i = lowest set rxc bit; if lane i == 8'hFD, end frame with length += i.
REQ-021 SHALL, in FRAME, end frame as bad if lane i != 8'hFD (includes 8'hFE error, 8'h07 idle).
REQ-022 SHALL treat start word (REQ-017 pattern) seen in FRAME as bad end of current frame and immediate start of a new frame (stays FRAME, length 0).
REQ-023 SHALL saturate the 16-bit length at 16'hFFFF.
REQ-024 SHALL classify terminated frame good iff MIN_LEN <= length <= MAX_LEN; otherwise bad.
REQ-025 SHALL assert frame_done, update frame_ok, and increment good_cnt or bad_cnt exactly 2 clk156 cycles after the ending word is on the input ports.
REQ-026 SHALL let good_cnt, bad_cnt, byte_cnt wrap modulo 2^width.
REQ-027 SHALL, when clr is high, zero good_cnt, bad_cnt, byte_cnt next cycle; clr wins over a coincident increment; state machine, in_frame, frame_ok unaffected.
REQ-028 SHALL drive in_frame high from the cycle after start decode until the cycle after end decode.

Reset
REQ-029 SHALL, on sys_rst, asynchronously force IDLE, input registers to idle (rxd 64'h0707070707070707, rxc 8'hFF), length 0, in_frame 0, frame_done 0, frame_ok 0, all counters and last_len 0.
REQ-030 SHALL, on sys_rst asserted mid-frame, discard the partial frame without counting it.

Configuration
REQ-031 SHALL compile byte_cnt and last_len logic only when XGMII_RX_MONITOR_STATS_EN is defined; last_len updates with every frame_done, byte_cnt adds length for good frames only.
REQ-032 SHALL, without XGMII_RX_MONITOR_STATS_EN, keep both ports and tie byte_cnt and last_len to 0.

Verification
REQ-033 SHALL cover: start word, 8 data words, word {rxc 8'hFF, lane0 8'hFD, rest 8'h07} -> frame_done 2 cycles later, frame_ok 1, good_cnt 1, last_len 64, byte_cnt 64.
REQ-034 SHALL cover: start, 7 data words, word rxc 8'hF0 with lane 4 8'hFD -> length 60, frame_ok 0, bad_cnt 1, byte_cnt unchanged.
REQ-035 SHALL cover: start, 3 data words, word rxc 8'h04 lane 2 8'hFE -> bad_cnt 1, in_frame low after end.
REQ-036 SHALL cover: start, 4 data words, second start, 8 data words, terminate lane 0 -> bad_cnt 1, good_cnt 1.
REQ-037 SHALL cover: clr high in same cycle as good frame_done -> good_cnt 0 afterwards; sys_rst pulse mid-frame -> no count, in_frame 0.
REQ-038 SHALL cover: 200 back-to-back 64-byte frames, one idle word between each -> good_cnt 200, bad_cnt 0, byte_cnt 12800 with stats option, 0 without.
